a2d_scan_ctrl: RTL and testbench
================================

Name: a2d_scan_ctrl

Overview:
Autonomous scan sequencer that owns the A2D interface (strt_cnv/chnnl/cnv_cmplt/res handshake). On a periodic tick, it converts a fixed list of 4 channels in order: left load cell, right load cell, steering pot, battery. Each result is latched into a dedicated holding register for downstream balance/steer/battery logic. It handles scan overrun and hung-conversion timeout so consumers always see the last good values.

Parameters:
SCAN_PERIOD, 4096, clocks between scan start ticks (min 16)
TIMEOUT, 2048, max clocks from strt_cnv to cnv_cmplt before abort (min 8)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scanning enable (level)
strt_cnv  out  1  one-cycle start pulse to A2D interface
chnnl  out  3  channel select to A2D interface
cnv_cmplt  in  1  A2D conversion complete (level; cleared by interface on strt_cnv)
res  in  12  A2D result; valid while cnv_cmplt=1
lft_ld  out  12  latest left load-cell result
rght_ld  out  12  latest right load-cell result
steer_pot  out  12  latest steering-pot result
batt  out  12  latest battery result
scan_done  out  1  one-cycle pulse after all 4 results of a scan are latched
ovr  out  1  one-cycle pulse when a tick arrives while a scan is already pending
tmo_err  out  1  one-cycle pulse when a conversion times out

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock. At reset: state=IDLE, all result regs=12'h000, strt_cnv=0, chnnl=3'd0, scan_done=0, ovr=0, tmo_err=0, period counter=0, index=0, pending=0. Reset mid-conversion aborts immediately; no partial result is latched.
- Channel order (index 0..3 -> chnnl): 0->3'd0 (lft_ld), 1->3'd4 (rght_ld), 2->3'd5 (steer_pot), 3->3'd6 (batt).
- Period counter: free-running whenever en=1; counts 0..SCAN_PERIOD-1, then wraps. tick=1 in the cycle the count equals SCAN_PERIOD-1. When en=0, the counter is held at 0 and pending is cleared.
- pending: set on tick; cleared when a scan starts. If tick arrives while pending is already 1 or a scan is in progress, pending is (re)set and ovr pulses. Multiple ticks collapse to one pending scan.
- FSM states: IDLE, START, WAIT, CAPT.
- IDLE: if pending (or tick this cycle) and en -> START; clear pending; index=0.
- START: strt_cnv=1 for exactly this cycle; chnnl=map(index); timeout counter cleared. -> WAIT.
- WAIT: chnnl held stable. If cnv_cmplt=1 -> CAPT. Else if timeout count reaches TIMEOUT-1 -> IDLE with tmo_err pulse; index reset to 0; no regs updated.
- CAPT: the result register selected by index <= res (one cycle after cnv_cmplt was first seen; res is still valid because cnv_cmplt is held). If index=3: scan_done pulses this cycle, index<=0, -> IDLE. Else index+1, -> START.
- Latency: strt_cnv to register update = conversion time + 2 clk. Back-to-back channels have 2 idle clocks between cnv_cmplt and the next strt_cnv.
- en dropped mid-scan: the current scan completes normally (all 4 channels); no new scan starts.
- Result registers update only in CAPT. Each update is atomic per channel; a scan is not atomic across channels.
- chnnl changes only on entry to START; never during WAIT.
- Timeout counter width is clog2(TIMEOUT). It saturates and is not free-running.

Decomposition:
- Package a2d_pkg: scan state typedef enum {IDLE,START,WAIT,CAPT}; localparam channel constants CH_LFT_LD=3'd0, CH_RGHT_LD=3'd4, CH_STEER=3'd5, CH_BATT=3'd6; NUM_CH=4.
- Sub-module: a2d_scan_timer (period counter + tick + pending/ovr logic). The FSM, timeout and result registers stay in the top.

Test Plan:
- Reset then en=1, SCAN_PERIOD=64, model returning res=12'h100+chnnl with 20-clk latency -> strt_cnv pulses with chnnl 0,4,5,6; lft_ld=12'h100, rght_ld=12'h104, steer_pot=12'h105, batt=12'h106; one scan_done; next scan begins at the following tick.
- en=0 from reset for 500 clks -> no strt_cnv; all outputs 0.
- SCAN_PERIOD=16 with 30-clk conversion latency -> ovr pulses; only one pending scan executes after the current one; no lost or duplicated channels.
- Model never asserts cnv_cmplt on chnnl=5, TIMEOUT=32 -> tmo_err pulse 32 clks after strt_cnv; steer_pot/batt unchanged; next tick restarts at chnnl=0.
- Drop en during the chnnl=4 conversion -> channels 5 and 6 still convert; scan_done fires; no further strt_cnv.
- Assert rst_n=0 during WAIT -> all outputs 0 asynchronously; after release, no capture occurs from the stale cnv_cmplt.

Source files
------------

// File: rtl/a2d_scan_ctrl_pkg.sv
// Shared types and constants for the A2D scan sequencer: FSM states,
// A2D channel codes and the scan-index to channel mapping.
package a2d_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      CAPT  = 2'd3
   } scan_state_t;

   localparam logic [2:0] CH_LFT_LD  = 3'd0;
   localparam logic [2:0] CH_RGHT_LD = 3'd4;
   localparam logic [2:0] CH_STEER   = 3'd5;
   localparam logic [2:0] CH_BATT    = 3'd6;

   localparam int NUM_CH = 4;
   localparam int IDX_W  = 2;

   function automatic logic [2:0] ch_map(input logic [IDX_W-1:0] idx);
      logic [2:0] ch;
      case (idx)
         2'd0:    ch = CH_LFT_LD;
         2'd1:    ch = CH_RGHT_LD;
         2'd2:    ch = CH_STEER;
         default: ch = CH_BATT;
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/a2d_scan_ctrl_timer.sv
// Scan period generator: free-running period counter, tick, and the
// single-entry pending-scan flag with overrun detection.
import a2d_pkg::*;

module a2d_scan_timer #(
   parameter int SCAN_PERIOD = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_busy,
   input  logic i_start,
   output logic o_tick,
   output logic o_pending,
   output logic o_ovr
);

   localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_pending;
   logic             r_ovr;
   logic             w_tick;

   assign w_tick = i_en && (r_cnt == CNT_W'(SCAN_PERIOD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         // A tick that finds a scan already queued or running collapses into one pending scan.
         r_ovr <= w_tick && (r_pending || i_busy);
         if (!i_en) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
         end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (i_start)
               r_pending <= 1'b0;
            else if (w_tick)
               r_pending <= 1'b1;
         end
      end
   end

   assign o_tick    = w_tick;
   assign o_pending = r_pending;
   assign o_ovr     = r_ovr;

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Autonomous A2D scan sequencer: converts left/right load cell, steering pot
// and battery in order on each period tick and holds the last good results.
import a2d_pkg::*;

module a2d_scan_ctrl #(
   parameter int SCAN_PERIOD = 4096,
   parameter int TIMEOUT     = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        strt_cnv,
   output logic [2:0]  chnnl,
   input  logic        cnv_cmplt,
   input  logic [11:0] res,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        scan_done,
   output logic        ovr,
   output logic        tmo_err
);

   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   scan_state_t      r_state;
   logic [IDX_W-1:0] r_idx;
   logic [TMO_W-1:0] r_tmo;
   logic             r_strt_cnv;
   logic [2:0]       r_chnnl;
   logic [11:0]      r_lft_ld;
   logic [11:0]      r_rght_ld;
   logic [11:0]      r_steer_pot;
   logic [11:0]      r_batt;
   logic             r_scan_done;
   logic             r_tmo_err;

   logic             w_tick;
   logic             w_pending;
   logic             w_ovr;
   logic             w_busy;
   logic             w_start;
   logic [IDX_W-1:0] w_idx_nxt;

   assign w_busy    = (r_state != IDLE);
   assign w_start   = (r_state == IDLE) && en && (w_pending || w_tick);
   assign w_idx_nxt = r_idx + 1'b1;

   a2d_scan_timer #(
      .SCAN_PERIOD (SCAN_PERIOD)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (en),
      .i_busy    (w_busy),
      .i_start   (w_start),
      .o_tick    (w_tick),
      .o_pending (w_pending),
      .o_ovr     (w_ovr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_tmo       <= '0;
         r_strt_cnv  <= 1'b0;
         r_chnnl     <= 3'd0;
         r_lft_ld    <= 12'h000;
         r_rght_ld   <= 12'h000;
         r_steer_pot <= 12'h000;
         r_batt      <= 12'h000;
         r_scan_done <= 1'b0;
         r_tmo_err   <= 1'b0;
      end else begin
         r_strt_cnv  <= 1'b0;
         r_scan_done <= 1'b0;
         r_tmo_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_idx      <= '0;
                  r_chnnl    <= ch_map('0);
                  r_strt_cnv <= 1'b1;
                  r_tmo      <= '0;
                  r_state    <= START;
               end
            end
            START: begin
               // The timeout window is measured from the strt_cnv cycle itself.
               r_tmo   <= r_tmo + 1'b1;
               r_state <= WAIT;
            end
            WAIT: begin
               if (cnv_cmplt) begin
                  r_state <= CAPT;
               end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                  r_tmo_err <= 1'b1;
                  r_idx     <= '0;
                  r_state   <= IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            CAPT: begin
               case (r_idx)
                  2'd0:    r_lft_ld    <= res;
                  2'd1:    r_rght_ld   <= res;
                  2'd2:    r_steer_pot <= res;
                  default: r_batt      <= res;
               endcase
               if (r_idx == IDX_W'(NUM_CH - 1)) begin
                  r_scan_done <= 1'b1;
                  r_idx       <= '0;
                  r_state     <= IDLE;
               end else begin
                  r_idx      <= w_idx_nxt;
                  r_chnnl    <= ch_map(w_idx_nxt);
                  r_strt_cnv <= 1'b1;
                  r_tmo      <= '0;
                  r_state    <= START;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign strt_cnv  = r_strt_cnv;
   assign chnnl     = r_chnnl;
   assign lft_ld    = r_lft_ld;
   assign rght_ld   = r_rght_ld;
   assign steer_pot = r_steer_pot;
   assign batt      = r_batt;
   assign scan_done = r_scan_done;
   assign ovr       = w_ovr;
   assign tmo_err   = r_tmo_err;

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl with a reactive A2D model returning
// res = 12'h100 + chnnl after a programmable latency.
`timescale 1ns/1ps
module tb_a2d_scan_ctrl;

   localparam int SP = 64;
   localparam int TO = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        cnv_cmplt = 1'b0;
   logic [11:0] res = 12'h000;
   logic        strt_cnv, scan_done, ovr, tmo_err;
   logic [2:0]  chnnl;
   logic [11:0] lft_ld, rght_ld, steer_pot, batt;

   always #5 clk = ~clk;

   a2d_scan_ctrl #(.SCAN_PERIOD(SP), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
      .cnv_cmplt(cnv_cmplt), .res(res), .lft_ld(lft_ld), .rght_ld(rght_ld),
      .steer_pot(steer_pot), .batt(batt), .scan_done(scan_done), .ovr(ovr),
      .tmo_err(tmo_err)
   );

   // A2D model: clears cnv_cmplt on strt_cnv, raises it lat clocks later
   int         lat = 10;
   int         hang_ch = -1;
   int         m_cnt = 0;
   bit         m_busy = 1'b0;
   logic [2:0] m_ch = 3'd0;
   always @(negedge clk) begin
      if (strt_cnv) begin
         cnv_cmplt <= 1'b0;
         m_busy    <= 1'b1;
         m_cnt     <= lat;
         m_ch      <= chnnl;
      end else if (m_busy) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_busy <= 1'b0;
            if (int'(m_ch) != hang_ch) begin
               cnv_cmplt <= 1'b1;
               res       <= 12'h100 + 12'(m_ch);
            end
         end
      end
   end

   int n_checks = 0;
   int n_pass = 0;
   logic [2:0] EXP_CH [4] = '{3'd0, 3'd4, 3'd5, 3'd6};

   // Observation log filled by run()
   int         ns, nd, no, nt, t_done, t_tmo, t_lft, chg;
   int         st_t [16];
   logic [2:0] st_c [16];

   task automatic do_reset();
      en = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run(input int ncyc, input bit drop_at_ch4);
      logic [2:0] last;
      last = chnnl;
      ns = 0; nd = 0; no = 0; nt = 0; t_done = -1; t_tmo = -1; t_lft = -1; chg = 0;
      for (int i = 0; i < 16; i++) begin st_t[i] = -1; st_c[i] = 3'd7; end
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         if (strt_cnv) begin
            if (ns < 16) begin st_t[ns] = n; st_c[ns] = chnnl; end
            ns++;
            if (drop_at_ch4 && chnnl == 3'd4) en = 1'b0;
         end else if (chnnl !== last) chg++;
         last = chnnl;
         if (scan_done) begin if (nd == 0) t_done = n; nd++; end
         if (ovr) no++;
         if (tmo_err) begin if (nt == 0) t_tmo = n; nt++; end
         if (t_lft < 0 && lft_ld == 12'h100) t_lft = n;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (strt_cnv !== 1'b0) $display("FAIL rst_strt: got %b want 0", strt_cnv); else n_pass++;
      n_checks++; if (chnnl !== 3'd0) $display("FAIL rst_chnnl: got %0d want 0", chnnl); else n_pass++;
      n_checks++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0)
         $display("FAIL rst_regs: got %h want 0", {lft_ld, rght_ld, steer_pot, batt}); else n_pass++;
      n_checks++; if ({scan_done, ovr, tmo_err} !== 3'b000)
         $display("FAIL rst_flags: got %b want 000", {scan_done, ovr, tmo_err}); else n_pass++;
   endtask

   task automatic test_disabled();
      do_reset();
      run(500, 1'b0);
      n_checks++; if (ns !== 0) $display("FAIL dis_strt: got %0d starts want 0", ns); else n_pass++;
      n_checks++; if ({lft_ld, rght_ld, steer_pot, batt, 3'(chnnl)} !== 51'h0)
         $display("FAIL dis_outs: got %h want 0", {lft_ld, rght_ld, steer_pot, batt}); else n_pass++;
      n_checks++; if (nd + no + nt !== 0) $display("FAIL dis_pulses: got %0d want 0", nd + no + nt); else n_pass++;
   endtask

   task automatic test_scan();
      do_reset();
      lat = 10; hang_ch = -1; en = 1'b1;
      run(130, 1'b0);
      n_checks++; if (ns !== 5) $display("FAIL scan_nstrt: got %0d want 5", ns); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (st_t[i] !== 64 + 12 * i) $display("FAIL scan_t%0d: got %0d want %0d", i, st_t[i], 64 + 12 * i); else n_pass++;
         n_checks++; if (st_c[i] !== EXP_CH[i]) $display("FAIL scan_ch%0d: got %0d want %0d", i, st_c[i], EXP_CH[i]); else n_pass++;
      end
      n_checks++; if (st_t[4] !== 128 || st_c[4] !== 3'd0)
         $display("FAIL scan_next: got t=%0d ch=%0d want t=128 ch=0", st_t[4], st_c[4]); else n_pass++;
      n_checks++; if (t_lft !== 76) $display("FAIL scan_lat: got %0d want 76", t_lft); else n_pass++;
      n_checks++; if (t_done !== 112 || nd !== 1) $display("FAIL scan_done: got t=%0d n=%0d want t=112 n=1", t_done, nd); else n_pass++;
      n_checks++; if ({lft_ld, rght_ld, steer_pot, batt} !== {12'h100, 12'h104, 12'h105, 12'h106})
         $display("FAIL scan_regs: got %h want 100104105106", {lft_ld, rght_ld, steer_pot, batt}); else n_pass++;
      n_checks++; if (chg !== 0) $display("FAIL scan_chstable: got %0d changes want 0", chg); else n_pass++;
      n_checks++; if (no + nt !== 0) $display("FAIL scan_err: got %0d ovr/tmo want 0", no + nt); else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_overrun();
      int exp_t [9] = '{64, 96, 128, 160, 193, 225, 257, 289, 322};
      do_reset();
      lat = 30; hang_ch = -1; en = 1'b1;
      run(330, 1'b0);
      n_checks++; if (ns !== 9) $display("FAIL ovr_nstrt: got %0d want 9", ns); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         n_checks++; if (st_t[i] !== exp_t[i] || st_c[i] !== EXP_CH[i % 4])
            $display("FAIL ovr_strt%0d: got t=%0d ch=%0d want t=%0d ch=%0d", i, st_t[i], st_c[i], exp_t[i], EXP_CH[i % 4]); else n_pass++;
      end
      n_checks++; if (no !== 4) $display("FAIL ovr_count: got %0d want 4", no); else n_pass++;
      n_checks++; if (nd !== 2 || t_done !== 192) $display("FAIL ovr_done: got n=%0d t=%0d want n=2 t=192", nd, t_done); else n_pass++;
      n_checks++; if ({lft_ld, rght_ld, steer_pot, batt} !== {12'h100, 12'h104, 12'h105, 12'h106})
         $display("FAIL ovr_regs: got %h want 100104105106", {lft_ld, rght_ld, steer_pot, batt}); else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      lat = 10; hang_ch = 5; en = 1'b1;
      run(130, 1'b0);
      n_checks++; if (ns !== 4) $display("FAIL tmo_nstrt: got %0d want 4", ns); else n_pass++;
      n_checks++; if (st_t[2] !== 88 || st_c[2] !== 3'd5) $display("FAIL tmo_hungstrt: got t=%0d ch=%0d want t=88 ch=5", st_t[2], st_c[2]); else n_pass++;
      n_checks++; if (t_tmo !== 120 || nt !== 1) $display("FAIL tmo_pulse: got t=%0d n=%0d want t=120 n=1", t_tmo, nt); else n_pass++;
      n_checks++; if (st_t[3] !== 128 || st_c[3] !== 3'd0) $display("FAIL tmo_restart: got t=%0d ch=%0d want t=128 ch=0", st_t[3], st_c[3]); else n_pass++;
      n_checks++; if ({steer_pot, batt} !== 24'h0) $display("FAIL tmo_keep: got %h want 000000", {steer_pot, batt}); else n_pass++;
      n_checks++; if ({lft_ld, rght_ld} !== {12'h100, 12'h104}) $display("FAIL tmo_good: got %h want 100104", {lft_ld, rght_ld}); else n_pass++;
      n_checks++; if (nd !== 0) $display("FAIL tmo_done: got %0d want 0", nd); else n_pass++;
      en = 1'b0; hang_ch = -1;
   endtask

   task automatic test_en_drop();
      do_reset();
      lat = 10; hang_ch = -1; en = 1'b1;
      run(200, 1'b1);
      n_checks++; if (ns !== 4) $display("FAIL drop_nstrt: got %0d want 4", ns); else n_pass++;
      n_checks++; if (st_c[2] !== 3'd5 || st_c[3] !== 3'd6) $display("FAIL drop_tail: got %0d,%0d want 5,6", st_c[2], st_c[3]); else n_pass++;
      n_checks++; if (nd !== 1 || t_done !== 112) $display("FAIL drop_done: got n=%0d t=%0d want n=1 t=112", nd, t_done); else n_pass++;
      n_checks++; if ({steer_pot, batt} !== {12'h105, 12'h106}) $display("FAIL drop_regs: got %h want 105106", {steer_pot, batt}); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      lat = 10; hang_ch = -1; en = 1'b1;
      run(86, 1'b0);
      #2;
      n_checks++; if (chnnl !== 3'd4 || lft_ld !== 12'h100) $display("FAIL mid_pre: got ch=%0d lft=%h want ch=4 lft=100", chnnl, lft_ld); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (chnnl !== 3'd0 || lft_ld !== 12'h000) $display("FAIL mid_async: got ch=%0d lft=%h want ch=0 lft=000", chnnl, lft_ld); else n_pass++;
      en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(40, 1'b0);
      n_checks++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0)
         $display("FAIL mid_nocapt: got %h want 0", {lft_ld, rght_ld, steer_pot, batt}); else n_pass++;
      n_checks++; if (ns + nd !== 0) $display("FAIL mid_idle: got %0d events want 0", ns + nd); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_disabled();
      test_scan();
      test_overrun();
      test_timeout();
      test_en_drop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
